// File: rtl/tug_of_war_ctrl.sv
// -----------------------------------------------------------------------------
// tug_of_war_ctrl
//
// Game controller for the tug-of-war playfield. Conditions the two raw player
// keys (two-flop synchroniser plus rising-edge detector each), cancels
// simultaneous presses, and walks a single lit position along a row of
// NUM_LIGHTS lamps. A press that would push the light off either end wins the
// round for that player. A round is followed by a release/restart handshake:
//   PLAY    -> WIN      on the winning press
//   WIN     -> RESTART  once both synchronised keys read low in the same cycle
//   RESTART -> PLAY     exactly RESTART_CYCLES edges after entering RESTART
//
// Parameters
//   NUM_LIGHTS      number of lamps; odd, >= 3; centre index NUM_LIGHTS/2
//   SCORE_W         width of each saturating score counter
//   RESTART_CYCLES  idle cycles spent in RESTART; >= 1
//
// Ports
//   clk           in   clock, all state on the rising edge
//   reset         in   synchronous, active-high reset
//   key_l, key_r  in   raw player keys, active-high, asynchronous to clk
//   lights        out  one-hot lit position (MSB = leftmost), all-0 outside PLAY
//   left_score    out  left-player wins, saturating
//   right_score   out  right-player wins, saturating
//   winner        out  2'b00 none, 2'b10 left won, 2'b01 right won
//   round_active  out  high while in PLAY
//
// Every output is a flop; the key path always passes through the
// synchroniser and the state registers before reaching any output.
// -----------------------------------------------------------------------------
module tug_of_war_ctrl #(
    parameter int NUM_LIGHTS     = 9,
    parameter int SCORE_W        = 3,
    parameter int RESTART_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_l,
    input  logic                  key_r,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]    left_score,
    output logic [SCORE_W-1:0]    right_score,
    output logic [1:0]            winner,
    output logic                  round_active
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int POS_W = $clog2(NUM_LIGHTS);
    localparam int CNT_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

    localparam logic [POS_W-1:0]   POS_CENTRE    = POS_W'(NUM_LIGHTS / 2);
    localparam logic [POS_W-1:0]   POS_LEFT_END  = POS_W'(NUM_LIGHTS - 1);
    localparam logic [POS_W-1:0]   POS_RIGHT_END = {POS_W{1'b0}};
    localparam logic [POS_W-1:0]   POS_ONE       = POS_W'(1);

    localparam logic [CNT_W-1:0]   CNT_LOAD      = CNT_W'(RESTART_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE       = CNT_W'(1);

    localparam logic [SCORE_W-1:0] SCORE_ZERO    = {SCORE_W{1'b0}};

    localparam logic [1:0]         WIN_NONE      = 2'b00;
    localparam logic [1:0]         WIN_LEFT      = 2'b10;
    localparam logic [1:0]         WIN_RIGHT     = 2'b01;

    typedef enum logic [1:0] {
        ST_PLAY    = 2'b00,
        ST_WIN     = 2'b01,
        ST_RESTART = 2'b10
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // One-hot lamp pattern for a position index (bit 0 = rightmost lamp).
    function automatic logic [NUM_LIGHTS-1:0] pos_to_onehot(input logic [POS_W-1:0] pos);
        logic [NUM_LIGHTS-1:0] v;
        v = {NUM_LIGHTS{1'b0}};
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            v[i] = (pos == POS_W'(i));
        end
        return v;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        if (&s) begin
            r = s;
        end else begin
            r = s + SCORE_W'(1);
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Key conditioning
    // -------------------------------------------------------------------------
    // All conditioning flops reset to 1 so a key held through reset looks like
    // a continuing high level and produces no press.
    logic key_l_meta_r, key_l_sync_r, key_l_prev_r;
    logic key_r_meta_r, key_r_sync_r, key_r_prev_r;
    logic press_l_s, press_r_s;
    logic move_l_s, move_r_s;

    // Left key: two-flop synchroniser followed by the edge-detect history flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_l_meta_r <= 1'b1;
            key_l_sync_r <= 1'b1;
            key_l_prev_r <= 1'b1;
        end else begin
            key_l_meta_r <= key_l;
            key_l_sync_r <= key_l_meta_r;
            key_l_prev_r <= key_l_sync_r;
        end
    end

    // Right key: two-flop synchroniser followed by the edge-detect history flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_r_meta_r <= 1'b1;
            key_r_sync_r <= 1'b1;
            key_r_prev_r <= 1'b1;
        end else begin
            key_r_meta_r <= key_r;
            key_r_sync_r <= key_r_meta_r;
            key_r_prev_r <= key_r_sync_r;
        end
    end

    // Rising-edge pulses and arbitration: simultaneous presses cancel out.
    always_comb begin
        press_l_s = key_l_sync_r & ~key_l_prev_r;
        press_r_s = key_r_sync_r & ~key_r_prev_r;
        move_l_s  = press_l_s & ~press_r_s;
        move_r_s  = press_r_s & ~press_l_s;
    end

    // -------------------------------------------------------------------------
    // Game state
    // -------------------------------------------------------------------------
    state_t               state_r,       state_next_s;
    logic [POS_W-1:0]     pos_r,         pos_next_s;
    logic [CNT_W-1:0]     cnt_r,         cnt_next_s;
    logic [1:0]           winner_r,      winner_next_s;
    logic [SCORE_W-1:0]   left_score_r,  left_score_next_s;
    logic [SCORE_W-1:0]   right_score_r, right_score_next_s;
    logic [NUM_LIGHTS-1:0] lights_r,     lights_next_s;
    logic                 round_active_r, round_active_next_s;

    // Next-state logic for the round FSM, position, scores and restart counter.
    always_comb begin
        state_next_s       = state_r;
        pos_next_s         = pos_r;
        cnt_next_s         = cnt_r;
        winner_next_s      = winner_r;
        left_score_next_s  = left_score_r;
        right_score_next_s = right_score_r;

        case (state_r)
            ST_PLAY: begin
                if (move_l_s) begin
                    if (pos_r == POS_LEFT_END) begin
                        state_next_s      = ST_WIN;
                        winner_next_s     = WIN_LEFT;
                        left_score_next_s = sat_inc(left_score_r);
                    end else begin
                        pos_next_s = pos_r + POS_ONE;
                    end
                end else if (move_r_s) begin
                    if (pos_r == POS_RIGHT_END) begin
                        state_next_s       = ST_WIN;
                        winner_next_s      = WIN_RIGHT;
                        right_score_next_s = sat_inc(right_score_r);
                    end else begin
                        pos_next_s = pos_r - POS_ONE;
                    end
                end else begin
                    pos_next_s = pos_r;
                end
            end

            ST_WIN: begin
                // Both players must have let go before the round can restart.
                if (!key_l_sync_r && !key_r_sync_r) begin
                    state_next_s = ST_RESTART;
                    cnt_next_s   = CNT_LOAD;
                end else begin
                    state_next_s = ST_WIN;
                end
            end

            ST_RESTART: begin
                // Counter loaded with N-1 on entry, so PLAY follows N edges later.
                if (cnt_r == CNT_ZERO) begin
                    state_next_s  = ST_PLAY;
                    pos_next_s    = POS_CENTRE;
                    winner_next_s = WIN_NONE;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end

            default: begin
                // Unreachable encoding: recover into a clean round.
                state_next_s  = ST_PLAY;
                pos_next_s    = POS_CENTRE;
                winner_next_s = WIN_NONE;
                cnt_next_s    = CNT_ZERO;
            end
        endcase
    end

    // Output values computed from the next state so they can be registered.
    always_comb begin
        lights_next_s       = {NUM_LIGHTS{1'b0}};
        round_active_next_s = 1'b0;
        if (state_next_s == ST_PLAY) begin
            lights_next_s       = pos_to_onehot(pos_next_s);
            round_active_next_s = 1'b1;
        end else begin
            lights_next_s       = {NUM_LIGHTS{1'b0}};
            round_active_next_s = 1'b0;
        end
    end

    // State and output registers; reset starts a fresh round at the centre.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_PLAY;
            pos_r          <= POS_CENTRE;
            cnt_r          <= CNT_ZERO;
            winner_r       <= WIN_NONE;
            left_score_r   <= SCORE_ZERO;
            right_score_r  <= SCORE_ZERO;
            lights_r       <= pos_to_onehot(POS_CENTRE);
            round_active_r <= 1'b1;
        end else begin
            state_r        <= state_next_s;
            pos_r          <= pos_next_s;
            cnt_r          <= cnt_next_s;
            winner_r       <= winner_next_s;
            left_score_r   <= left_score_next_s;
            right_score_r  <= right_score_next_s;
            lights_r       <= lights_next_s;
            round_active_r <= round_active_next_s;
        end
    end

    assign lights       = lights_r;
    assign left_score   = left_score_r;
    assign right_score  = right_score_r;
    assign winner       = winner_r;
    assign round_active = round_active_r;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tug_of_war_ctrl
//
// Directed bench for tug_of_war_ctrl with default parameters
// (NUM_LIGHTS=9, SCORE_W=3, RESTART_CYCLES=4). Inputs change and outputs are
// sampled 1 time unit after each rising edge. A key raised after edge k is
// first sampled at edge k+1, so its move is visible after edge k+3.
// -----------------------------------------------------------------------------
module tb_tug_of_war_ctrl;

    logic       clk;
    logic       reset;
    logic       key_l;
    logic       key_r;
    logic [8:0] lights;
    logic [2:0] left_score;
    logic [2:0] right_score;
    logic [1:0] winner;
    logic       round_active;

    int n_checks = 0;
    int n_fail   = 0;

    tug_of_war_ctrl #(
        .NUM_LIGHTS     (9),
        .SCORE_W        (3),
        .RESTART_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_l        (key_l),
        .key_r        (key_r),
        .lights       (lights),
        .left_score   (left_score),
        .right_score  (right_score),
        .winner       (winner),
        .round_active (round_active)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One press: keys high 3 edges (move lands on the 3rd), then low 3 edges.
    task automatic press(input logic l, input logic r);
        key_l = l;
        key_r = r;
        step(3);
        key_l = 1'b0;
        key_r = 1'b0;
        step(3);
    endtask

    initial begin
        reset = 1'b1;
        key_l = 1'b1;   // held across reset release
        key_r = 1'b0;

        // 1. Reset state, key_l held through release gives no move.
        step(2);
        check_value("rst_lights", 32'(lights), 32'h010);
        check_value("rst_lscore", 32'(left_score), 32'd0);
        check_value("rst_rscore", 32'(right_score), 32'd0);
        check_value("rst_winner", 32'(winner), 32'd0);
        check_value("rst_active", 32'(round_active), 32'd1);
        reset = 1'b0;
        step(6);
        check_value("held_key_nomove", 32'(lights), 32'h010);
        key_l = 1'b0;
        step(4);
        check_value("release_nomove", 32'(lights), 32'h010);

        // 2. key_r high 5 cycles: one move, visible on the 3rd edge.
        key_r = 1'b1;
        step(2);
        check_value("r_latency_early", 32'(lights), 32'h010);
        step(1);
        check_value("r_latency_move", 32'(lights), 32'h008);
        step(2);
        key_r = 1'b0;
        step(5);
        check_value("r_single_move", 32'(lights), 32'h008);

        // 3. Simultaneous rise cancels; then back to centre and L,R,L.
        key_l = 1'b1;
        key_r = 1'b1;
        step(5);
        check_value("both_cancel", 32'(lights), 32'h008);
        key_l = 1'b0;
        key_r = 1'b0;
        step(4);
        press(1'b1, 1'b0);
        check_value("to_centre", 32'(lights), 32'h010);
        press(1'b1, 1'b0);
        check_value("alt_l1", 32'(lights), 32'h020);
        press(1'b0, 1'b1);
        check_value("alt_r", 32'(lights), 32'h010);
        press(1'b1, 1'b0);
        check_value("alt_l2", 32'(lights), 32'h020);

        // 4. From centre, five left presses win; hold; release; restart timing.
        press(1'b0, 1'b1);
        check_value("t4_centre", 32'(lights), 32'h010);
        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0);
        end
        check_value("left_end", 32'(lights), 32'h100);
        key_l = 1'b1;
        step(3);
        check_value("lwin_lights", 32'(lights), 32'h000);
        check_value("lwin_winner", 32'(winner), 32'h2);
        check_value("lwin_lscore", 32'(left_score), 32'd1);
        check_value("lwin_active", 32'(round_active), 32'd0);
        step(10);
        check_value("hold_winner", 32'(winner), 32'h2);
        check_value("hold_active", 32'(round_active), 32'd0);
        check_value("hold_lscore", 32'(left_score), 32'd1);
        // Release sampled next edge, synced one edge later, RESTART the edge
        // after that, PLAY 4 edges after entering RESTART: 7 edges in all.
        key_l = 1'b0;
        step(6);
        check_value("restart_active", 32'(round_active), 32'd0);
        check_value("restart_winner", 32'(winner), 32'h2);
        check_value("restart_lights", 32'(lights), 32'h000);
        step(1);
        check_value("replay_active", 32'(round_active), 32'd1);
        check_value("replay_lights", 32'(lights), 32'h010);
        check_value("replay_winner", 32'(winner), 32'h0);

        // 5. Eight right wins: score saturates at 7, winner still set.
        for (int w = 1; w <= 8; w++) begin
            for (int p = 0; p < 5; p++) begin
                press(1'b0, 1'b1);
            end
            check_value($sformatf("rwin%0d_score", w), 32'(right_score), (w > 7) ? 32'd7 : 32'(w));
            check_value($sformatf("rwin%0d_winner", w), 32'(winner), 32'h1);
            step(5);
        end
        check_value("sat_lscore", 32'(left_score), 32'd1);
        check_value("sat_replay", 32'(lights), 32'h010);

        // 6. Left win to score 2, then reset while in RESTART.
        for (int p = 0; p < 5; p++) begin
            press(1'b1, 1'b0);
        end
        check_value("pre_rst_lscore", 32'(left_score), 32'd2);
        check_value("pre_rst_active", 32'(round_active), 32'd0);
        step(1);
        reset = 1'b1;
        step(1);
        check_value("midrst_lscore", 32'(left_score), 32'd0);
        check_value("midrst_rscore", 32'(right_score), 32'd0);
        check_value("midrst_lights", 32'(lights), 32'h010);
        check_value("midrst_winner", 32'(winner), 32'h0);
        check_value("midrst_active", 32'(round_active), 32'd1);
        reset = 1'b0;
        step(3);
        check_value("post_rst_lights", 32'(lights), 32'h010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
